// File: rtl/brwm_seq.sv
// rtl/brwm_seq.sv - BRWM self-test sequencer: fill with a pattern, read back, compare, report.
// Define BRWM_SEQ_LFSR_EN for an 8-bit Galois LFSR pattern instead of an incrementing one.
module brwm_seq #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] SEED   = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              mem_on_off,
  output logic              mem_rw,
  output logic              mem_clear,
  output logic              mem_pause,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              finished,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [7:0]        err_count
);

  localparam int WD_W = $clog2(DEPTH + 5);
  // Watchdog value seen on the cycle that would be the (DEPTH+4)th issued word.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DEPTH + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WRITE, S_TURN, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] pat, pat_step;
  logic [WD_W-1:0]   wd;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [7:0]        err_next;
  logic              issued, wd_fire, timeout_next;

`ifdef BRWM_SEQ_LFSR_EN
  if (DATA_W != 8) begin : g_lfsr_width_check
    $error("brwm_seq: BRWM_SEQ_LFSR_EN requires DATA_W == 8");
  end
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  assign pat_step = {1'b0, pat[DATA_W-1:1]} ^ (pat[0] ? DATA_W'(8'hB8) : '0);
`else
  assign pat_step = pat + 1'b1;
`endif

  always_comb begin
    state_n    = state;
    mem_on_off = 1'b0;
    mem_rw     = 1'b0;
    mem_clear  = 1'b0;
    mem_pause  = 1'b0;
    mem_wdata  = '0;
    issued     = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_CLEAR;
      S_CLEAR: begin
        mem_on_off = 1'b1;
        mem_clear  = 1'b1;
        mem_rw     = 1'b1;
        state_n    = S_WRITE;
      end
      S_WRITE: begin
        mem_on_off = 1'b1;
        mem_rw     = 1'b1;
        mem_pause  = stall;
        mem_wdata  = pat;
        issued     = !stall;
        if (issued && mem_done) state_n = S_TURN;
        else if (issued && wd == WD_LAST) begin
          wd_fire = 1'b1;
          state_n = S_DONE;
        end
      end
      S_TURN: begin
        mem_on_off = 1'b1;
        mem_clear  = 1'b1;
        state_n    = S_READ;
      end
      S_READ: begin
        mem_on_off = 1'b1;
        mem_pause  = stall;
        issued     = !stall;
        if (issued && mem_done) state_n = S_DRAIN;
        else if (issued && wd == WD_LAST) begin
          wd_fire = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    err_next = err_count;
    if (cmp_valid && (mem_rdata != cmp_exp) && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
  end

  assign timeout_next = timeout | wd_fire;
  assign busy         = (state != S_IDLE);
  assign finished     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pat       <= '0;
      wd        <= '0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_CLEAR || state == S_TURN) begin
        pat <= SEED;
        wd  <= '0;
      end else if (issued) begin
        pat <= pat_step;
        wd  <= wd + 1'b1;
      end
      // The word issued this cycle is checked against the read data of the next cycle.
      cmp_valid <= (state == S_READ) && issued && !wd_fire;
      cmp_exp   <= pat;
      if (state == S_IDLE && start) begin
        err_count <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        err_count <= err_next;
        timeout   <= timeout_next;
        if (state_n == S_DONE && state != S_DONE) begin
          pass <= (err_next == 8'd0) && !timeout_next;
          fail <= !((err_next == 8'd0) && !timeout_next);
        end
      end
    end
  end

endmodule

// File: tb/tb_brwm_seq.sv
// tb/tb_brwm_seq.sv - scoreboard bench for brwm_seq with behavioural BRWM models (DEPTH 16 and 300).
// Define BRWM_SEQ_LFSR_EN for both bench and RTL to exercise the LFSR pattern.
module tb_brwm_seq;

  localparam logic [7:0] SEED = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_req = 1'b0;
  logic stall = 1'b0;
  bit   sel = 1'b0;
  bit   flip_en = 1'b0, ff_mode = 1'b0, no_done = 1'b0, stall_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int fin_count = 0;

  typedef struct {
    int lat;
    bit pass;
    bit fail;
    bit tmo;
    int err;
  } res_t;

  logic [7:0] exp_wq[$];
  res_t       exp_res[$];
  res_t       mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int MD = (g == 0) ? 16 : 300;
    logic on_off, rw, clr, pause, done, busy, finished, pass, fail, timeout, start;
    logic [7:0] wdata, err_count;
    logic [7:0] rdata = 8'h00;
    logic [7:0] mem[MD];
    int addr = 0;

    assign start = start_req && (sel == g);
    assign done  = on_off && !clr && (addr == MD - 1) && !no_done;

    brwm_seq #(.DATA_W(8), .DEPTH(MD), .SEED(SEED)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .mem_on_off(on_off), .mem_rw(rw), .mem_clear(clr), .mem_pause(pause),
      .mem_wdata(wdata), .mem_rdata(rdata), .mem_done(done),
      .busy(busy), .finished(finished), .pass(pass), .fail(fail),
      .timeout(timeout), .err_count(err_count)
    );

    always @(posedge clk) begin
      if (clr) addr <= 0;
      else if (on_off && !pause) begin
        if (rw) mem[addr] <= wdata;
        addr <= (addr == MD - 1) ? 0 : addr + 1;
      end
      if (ff_mode) rdata <= 8'hFF;
      else rdata <= mem[addr] ^ {7'd0, flip_en && (addr == 3 || addr == 9)};
    end
  end

  logic a_on_off, a_rw, a_clr, a_pause, a_busy, a_fin, a_pass, a_fail, a_tmo;
  logic [7:0] a_wdata, a_err;
  assign a_on_off = sel ? gi[1].on_off    : gi[0].on_off;
  assign a_rw     = sel ? gi[1].rw        : gi[0].rw;
  assign a_clr    = sel ? gi[1].clr       : gi[0].clr;
  assign a_pause  = sel ? gi[1].pause     : gi[0].pause;
  assign a_busy   = sel ? gi[1].busy      : gi[0].busy;
  assign a_fin    = sel ? gi[1].finished  : gi[0].finished;
  assign a_pass   = sel ? gi[1].pass      : gi[0].pass;
  assign a_fail   = sel ? gi[1].fail      : gi[0].fail;
  assign a_tmo    = sel ? gi[1].timeout   : gi[0].timeout;
  assign a_wdata  = sel ? gi[1].wdata     : gi[0].wdata;
  assign a_err    = sel ? gi[1].err_count : gi[0].err_count;

  logic [25:0] out_vec;
  assign out_vec = {a_on_off, a_rw, a_clr, a_pause, a_wdata, a_busy, a_fin,
                    a_pass, a_fail, a_tmo, a_err};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [7:0] v;
    v = SEED;
`ifdef BRWM_SEQ_LFSR_EN
    for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
`else
    v = 8'(int'(SEED) + k);
`endif
    return v;
  endfunction

  // Stall is redrawn 1 time unit after every rising edge while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    stall = stall_en && ($urandom_range(0, 99) < 30);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_on_off && a_rw && !a_clr && !a_pause) begin
        if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
        else check("wdata", a_wdata, exp_wq.pop_front());
      end
      if (a_on_off && !a_clr) check("pause_follows_stall", a_pause, stall);
      if (a_fin) begin
        fin_count++;
        if (exp_res.size() == 0) check("unexpected_finished", 1, 0);
        else begin
          mon_r = exp_res.pop_front();
          if (mon_r.lat >= 0) check("finish_latency", cyc - t0 + 1, mon_r.lat);
          check("pass", a_pass, mon_r.pass);
          check("fail", a_fail, mon_r.fail);
          check("timeout", a_tmo, mon_r.tmo);
          check("err_count", a_err, mon_r.err);
        end
      end
    end
  end

  task automatic run(input bit inst, input bit flip, input bit ff, input bit nd,
                     input bit stl, input int restart_at);
    int d, nwr, err, fc;
    logic [7:0] rd;
    res_t r;
    sel = inst; flip_en = flip; ff_mode = ff; no_done = nd; stall_en = 1'b0;
    d   = inst ? 300 : 16;
    nwr = nd ? d + 4 : d;
    for (int k = 0; k < nwr; k++) exp_wq.push_back(pat(k));
    err = 0;
    if (!nd) begin
      for (int k = 0; k < d; k++) begin
        rd = ff ? 8'hFF : (pat(k) ^ 8'(flip && (k == 3 || k == 9)));
        if (rd != pat(k) && err < 255) err++;
      end
    end
    r.tmo  = nd;
    r.err  = err;
    r.pass = (err == 0) && !nd;
    r.fail = !r.pass;
    r.lat  = stl ? -1 : (nd ? nwr + 2 : 2 * d + 4);
    exp_res.push_back(r);
    @(posedge clk); #1;
    start_req = 1'b1; t0 = cyc + 1; stall_en = stl;
    @(posedge clk); #1;
    start_req = 1'b0;
    fc = fin_count;
    for (int i = 0; i < 5000 && fin_count == fc; i++) begin
      @(posedge clk); #1;
      start_req = (restart_at > 0 && i == restart_at);
    end
    start_req = 1'b0;
    stall_en = 1'b0;
    if (fin_count == fc) check("finish_wait_expired", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("pass_held", a_pass, r.pass);
    check("fail_held", a_fail, r.fail);
    check("timeout_held", a_tmo, r.tmo);
    check("busy_after_done", a_busy, 0);
    check("writes_consumed", exp_wq.size(), 0);
    exp_wq.delete();
    exp_res.delete();
  endtask

  initial begin
    int fc, i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'(out_vec), 0);
    rst_n = 1'b1;

    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // ideal memory
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // bit0 flipped at addresses 3 and 9
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // random stall
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);   // mem_done never arrives
    run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 100); // all-FF readback, start mid-run

    // Reset during READ: outputs clear at once, no finished pulse follows.
    sel = 1'b0; flip_en = 1'b0; ff_mode = 1'b0; no_done = 1'b0;
    for (int k = 0; k < 16; k++) exp_wq.push_back(pat(k));
    @(posedge clk); #1; start_req = 1'b1;
    @(posedge clk); #1; start_req = 1'b0;
    i = 0;
    while (i < 100 && !(a_on_off && !a_rw && !a_clr)) begin
      @(posedge clk); #1; i++;
    end
    check("reached_read", int'(i < 100), 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_read_outputs", int'(out_vec), 0);
    check("writes_before_reset", exp_wq.size(), 0);
    exp_wq.delete();
    fc = fin_count;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("no_finished_after_reset", fin_count, fc);

    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // recovery after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brwm_seq.md
Name: brwm_seq

Overview:
- Initiator/sequencer for the BRWM block-RAM write/read port; drives `on_off`, `rw`, `clear`, `pause` and `data_in`, and consumes `data_out` and `done`.
- On `start` it rewinds the memory, fills every location with a known pattern, rewinds again, reads every location back and compares it against the regenerated pattern.
- Reports pass/fail and a saturating error count; it is the self-test master for the BRWM in bring-up builds.

Parameters:
- DATA_W, 8, data width; must match the BRWM word width.
- DEPTH, 256, number of BRWM locations; used only by the timeout watchdog.
- SEED, 8'h01, first pattern value (and LFSR seed; must be nonzero when the LFSR is enabled).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a test; honoured only in IDLE.
- stall  in  1  back-pressure from the system; mapped to mem_pause.
- mem_on_off  out  1  BRWM enable.
- mem_rw  out  1  BRWM direction: 1 = write, 0 = read.
- mem_clear  out  1  BRWM address rewind.
- mem_pause  out  1  BRWM hold.
- mem_wdata  out  DATA_W  to BRWM data_in.
- mem_rdata  in  DATA_W  from BRWM data_out.
- mem_done  in  1  BRWM end-of-block flag.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  result; held until the next accepted start.
- fail  out  1  result; held until the next accepted start.
- timeout  out  1  watchdog fired; held like pass/fail.
- err_count  out  8  mismatch count, saturating at 255.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including mem_wdata, err_count and the pattern index k.
  - Memory contents are untouched.
  - Reset mid-run aborts the run immediately with no finished pulse.
- BRWM contract:
  - The address advances on every clk where on_off=1, pause=0 and clear=0.
  - clear=1 rewinds the address to 0.
  - Read data for an address appears on mem_rdata exactly 1 cycle after that address is issued.
  - mem_done is high in the cycle the last address (DEPTH-1) is issued.
- IDLE: mem_on_off=0. start=1 moves to CLEAR, zeroes err_count, pass, fail and timeout, and sets busy. start in any other state is ignored.
- CLEAR (1 cycle): mem_on_off=1, mem_clear=1, mem_rw=1. k=0, then go to WRITE.
- WRITE:
  - Outputs: mem_on_off=1, mem_rw=1, mem_pause=stall, mem_wdata=P(k).
  - k advances only on cycles with stall=0 ("issued" cycles).
  - mem_done=1 on an issued cycle moves to TURN.
- TURN (1 cycle): mem_clear=1, mem_rw=0, stall ignored. k=0, watchdog=0, then go to READ.
- READ:
  - Outputs: mem_rw=0, mem_pause=stall.
  - Each issued cycle loads a compare pipeline: valid=1, exp=P(k), k++.
  - Next cycle: if valid and mem_rdata!=exp, err_count increments (saturating).
  - A stalled cycle loads valid=0, but a compare already in the pipeline still completes.
  - mem_done on an issued cycle moves to DRAIN.
- DRAIN (1 cycle): mem_on_off=0, completes the final compare, then go to DONE.
- DONE (1 cycle):
  - finished=1, pass = (err_count==0 && !timeout), fail = !pass.
  - Then return to IDLE with busy=0.
- Watchdog:
  - Counts issued cycles in WRITE and READ.
  - If it reaches DEPTH+4 without mem_done: timeout=1, go directly to DONE, and fail=1.
- Pattern: P(k) = (SEED + k) mod 2^DATA_W.
- Simultaneous events:
  - stall together with mem_done: mem_done is ignored; the transition waits for an issued cycle.
  - Saturation at 255 holds for the rest of the run.

Optional Feature:
- Macro BRWM_SEQ_LFSR_EN.
- When defined:
  - P(k) comes from an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - P(0)=SEED; the LFSR advances one step per issued word.
  - The LFSR reloads SEED in CLEAR and TURN.
  - DATA_W must be 8; an elaboration-time error is raised otherwise.
- When undefined: incrementing pattern as above, and no LFSR logic is synthesised.

Test Plan:
- Ideal BRWM model, DEPTH=16, SEED=8'h01, one start pulse -> writes 01..10; finished after 1+16+1+16+1+1=36 cycles; pass=1, err_count=0.
- Same setup with the model flipping bit0 of read addresses 3 and 9 -> fail=1, err_count=2.
- Random stall at 30% in both WRITE and READ -> mem_pause follows stall, written data still 01..10 in order; pass=1.
- Model never asserts mem_done, DEPTH=16 -> timeout=1, fail=1, finished after 20 issued WRITE cycles.
- Model returns 8'hFF at every address with DEPTH=300 (address wraps) -> err_count stops at 255; a second start during the run is ignored; rst_n pulsed mid-READ -> all outputs 0 and no finished pulse.
- Build with BRWM_SEQ_LFSR_EN, SEED=8'h01 -> write data follows the LFSR sequence from 01; readback passes.
